// File: rtl/add_tree_pkg.sv
// Shared sizing helpers for the add_tree_reduce adder-tree stage.
package add_tree_pkg;

  localparam int CNT_WIDTH = 16;

  function automatic int tree_levels(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int full_sum_width(input int dw, input int n);
    return dw + tree_levels(n);
  endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered level of pairwise adders with a travelling valid bit.
module add_tree_level
  import add_tree_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int NUM_PAIRS = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en_i,
  input  logic                              vld_i,
  input  logic [2*NUM_PAIRS*IN_WIDTH-1:0]   data_i,
  output logic                              vld_o,
  output logic [NUM_PAIRS*(IN_WIDTH+1)-1:0] data_o
);

  localparam int OW = IN_WIDTH + 1;

  logic [NUM_PAIRS*OW-1:0] data_d;
  logic [NUM_PAIRS*OW-1:0] data_q;
  logic                    vld_q;

  // Pairwise sums, each one bit wider than its operands
  always_comb begin
    data_d = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      data_d[p*OW +: OW] = OW'(data_i[(2*p)*IN_WIDTH +: IN_WIDTH])
                         + OW'(data_i[(2*p+1)*IN_WIDTH +: IN_WIDTH]);
    end
  end

  // Level register; data only loads for valid entries so bubbles never carry X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (en_i) begin
      vld_q <= vld_i;
      if (vld_i) begin
        data_q <= data_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/add_tree_reduce.sv
// Pipelined, back-pressurable adder-tree reduction with a wrapping output counter.
// Optional macro ADD_TREE_SATURATE_EN: final resize saturates instead of truncating.
module add_tree_reduce
  import add_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 4,
  parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in [NUM_INPUTS],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [SUM_WIDTH-1:0]  out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  out_count
);

  localparam int LEVELS = tree_levels(NUM_INPUTS);
  localparam int NPAD   = 32'd1 << LEVELS;
  localparam int FULL_W = full_sum_width(DATA_WIDTH, NUM_INPUTS);

  logic                       stall_s;
  logic [NPAD*DATA_WIDTH-1:0] in_flat_s;
  logic [FULL_W-1:0]          full_s;
  logic [CNT_WIDTH-1:0]       cnt_d;
  logic [CNT_WIDTH-1:0]       cnt_q;

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;

  // Flatten the input array, zero-padding up to a power of two
  always_comb begin
    in_flat_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_flat_s[i*DATA_WIDTH +: DATA_WIDTH] = in[i];
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int IW = DATA_WIDTH + k - 1;
    localparam int NP = 32'd1 << (LEVELS - k);

    logic [2*NP*IW-1:0]   din_s;
    logic                 din_vld_s;
    logic [NP*(IW+1)-1:0] dout_s;
    logic                 vld_s;

    if (k == 1) begin : g_first
      assign din_s     = in_flat_s;
      assign din_vld_s = in_valid;
    end else begin : g_next
      assign din_s     = g_lvl[k-1].dout_s;
      assign din_vld_s = g_lvl[k-1].vld_s;
    end

    add_tree_level #(
      .IN_WIDTH  (IW),
      .NUM_PAIRS (NP)
    ) u_level (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (~stall_s),
      .vld_i  (din_vld_s),
      .data_i (din_s),
      .vld_o  (vld_s),
      .data_o (dout_s)
    );
  end

  assign full_s    = g_lvl[LEVELS].dout_s;
  assign out_valid = g_lvl[LEVELS].vld_s;

`ifdef ADD_TREE_SATURATE_EN
  if (FULL_W > SUM_WIDTH) begin : g_sat
    assign out = ((full_s >> SUM_WIDTH) != '0) ? {SUM_WIDTH{1'b1}} : SUM_WIDTH'(full_s);
  end else begin : g_ext
    assign out = SUM_WIDTH'(full_s);
  end
`else
  // Size cast truncates when narrower and zero-extends when wider
  assign out = SUM_WIDTH'(full_s);
`endif

  // Output transfer counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output transfer counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_count = cnt_q;

endmodule

// File: tb/tb_add_tree_reduce.sv
// Scoreboard bench for add_tree_reduce: random streaming, back-pressure, reset and wrap.
module tb_add_tree_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_a [4];
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [9:0]  out;
  logic [15:0] out_count;

  logic [7:0]  in3 [3];
  logic        v3, rdy3, ov3;
  logic [9:0]  o3;
  logic [15:0] c3;
  logic [7:0]  in1 [1];
  logic        v1, rdy1, ov1;
  logic [7:0]  o1;
  logic [15:0] c1;
  logic [7:0]  in8 [4];
  logic        v8, rdy8, ov8;
  logic [7:0]  o8;
  logic [15:0] c8;

  int total = 0;
  int bad   = 0;
  int exp_q [$];
  int n_push = 0;
  bit prev_stall = 1'b0;
  logic [9:0] prev_out = '0;

  always #5 clk = ~clk;

  add_tree_reduce #(.DATA_WIDTH(8), .NUM_INPUTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_a), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count));

  add_tree_reduce #(.DATA_WIDTH(8), .NUM_INPUTS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in(in3), .in_valid(v3), .in_ready(rdy3),
    .out(o3), .out_valid(ov3), .out_ready(1'b1), .out_count(c3));

  add_tree_reduce #(.DATA_WIDTH(8), .NUM_INPUTS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .in_valid(v1), .in_ready(rdy1),
    .out(o1), .out_valid(ov1), .out_ready(1'b1), .out_count(c1));

  add_tree_reduce #(.DATA_WIDTH(8), .NUM_INPUTS(4), .SUM_WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .in_valid(v8), .in_ready(rdy8),
    .out(o8), .out_valid(ov8), .out_ready(1'b1), .out_count(c8));

  task automatic chk(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive_rand(input bit v);
    in_valid = v;
    for (int j = 0; j < 4; j++) in_a[j] = 8'($urandom_range(0, 255));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(exp_q.size() == 0, name, exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: reference sums pushed on input transfers, popped on output transfers
  always @(negedge clk) begin
    int s;
    int e;
    if (!rst_n) begin
      exp_q.delete();
      n_push = 0;
      prev_stall = 1'b0;
    end else begin
      chk(in_ready == !(out_valid && !out_ready), "in_ready_rel", int'(in_ready),
          int'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk(out_valid && out == prev_out, "stall_hold", int'(out), int'(prev_out));
      end
      if (out_valid && out_ready) begin
        chk(exp_q.size() != 0, "unexpected_out", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(int'(out) == e, "sum", int'(out), e);
        end
      end
      if (in_valid && in_ready) begin
        s = 0;
        for (int j = 0; j < 4; j++) s += int'(in_a[j]);
        exp_q.push_back(s % 1024);
        n_push++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    v3 = 1'b0; v1 = 1'b0; v8 = 1'b0;
    for (int j = 0; j < 4; j++) begin in_a[j] = '0; in8[j] = '0; end
    for (int j = 0; j < 3; j++) in3[j] = '0;
    in1[0] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
    chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    chk(out_count == 16'd0, "rst_out_count", int'(out_count), 0);
    chk(out == 10'd0, "rst_out", int'(out), 0);
    chk(rdy3 && rdy1 && rdy8, "rst_in_ready_var", int'({rdy3, rdy1, rdy8}), 7);
    chk(!ov3 && !ov1 && !ov8, "rst_out_valid_var", int'({ov3, ov1, ov8}), 0);
    chk(c3 == 16'd0 && c1 == 16'd0 && c8 == 16'd0, "rst_count_var", int'(c3 | c1 | c8), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic reduce plus variant instances
    @(posedge clk); #1;
    in_a[0] = 8'd1; in_a[1] = 8'd2; in_a[2] = 8'd3; in_a[3] = 8'd4; in_valid = 1'b1;
    in3[0] = 8'd255; in3[1] = 8'd255; in3[2] = 8'd255; v3 = 1'b1;
    in1[0] = 8'hA5; v1 = 1'b1;
    in8[0] = 8'd200; in8[1] = 8'd100; in8[2] = 8'd0; in8[3] = 8'd0; v8 = 1'b1;
    @(negedge clk);
    chk(out_valid == 1'b0, "lat_c0", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; v3 = 1'b0; v1 = 1'b0; v8 = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "lat_c1", int'(out_valid), 0);
    chk(ov1 == 1'b1 && o1 == 8'hA5, "n1_pass", int'(o1), 165);
    @(negedge clk);
    chk(out_valid == 1'b1 && out == 10'd10, "basic_1234", int'(out), 10);
    chk(ov3 == 1'b1 && o3 == 10'd765, "n3_sum", int'(o3), 765);
`ifdef ADD_TREE_SATURATE_EN
    chk(ov8 == 1'b1 && o8 == 8'd255, "ovf_sat", int'(o8), 255);
`else
    chk(ov8 == 1'b1 && o8 == 8'd44, "ovf_trunc", int'(o8), 44);
`endif
    @(negedge clk);
    chk(out_count == 16'd1, "count_basic", int'(out_count), 1);

    // Streaming back-to-back
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      drive_rand(1'b1);
      chk(in_ready == 1'b1, "stream_in_ready", int'(in_ready), 1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain("stream_drain");
    chk(out_count == 16'd101, "count_stream", int'(out_count), 101);

    // Random back-pressure
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      drive_rand($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    drain("bp_drain");
    chk(out_count == 16'(n_push), "count_bp", int'(out_count), n_push);

    // Reset with two arrays in flight
    @(posedge clk); #1 drive_rand(1'b1);
    @(posedge clk); #1 drive_rand(1'b1);
    @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk(out_valid == 1'b0, "midrst_valid", int'(out_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(seen == 0, "midrst_no_output", seen, 0);
    chk(out_count == 16'd0, "midrst_count", int'(out_count), 0);

    // Counter wrap after 65536 transfers
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk); #1 drive_rand(1'b1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain("wrap_drain");
    chk(out_count == 16'd0, "count_wrap", int'(out_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
